// File: rtl/img_wr_pkg.sv
// Shared types and helpers for the image write sequencer.
// Holds the FSM state encoding, word geometry and the byte-enable helper.
package img_wr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    // Enables for 'count' lanes filled from lane 0 upward; 0 for an empty word.
    function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input logic [LANE_W:0] count);
        logic [BYTES_PER_WORD-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i < int'(count)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Byte-lane accumulator: one pixel per load into the next lane, clear empties the word.
// Single-cycle update; no flow control of its own, the FSM gates load/clear.
module pixel_packer
    import img_wr_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       clear,
    input  logic [7:0]                 pix_data,
    output logic [8*BYTES_PER_WORD-1:0] word_data,
    output logic [BYTES_PER_WORD-1:0]  byte_en,
    output logic                       last_lane
);

    logic [BYTES_PER_WORD-1:0][7:0] lanes;
    logic [LANE_W-1:0]              lane_idx;
    logic [BYTES_PER_WORD-1:0]      mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes    <= '0;
            lane_idx <= '0;
            mask     <= '0;
        end else if (clear) begin
            lanes    <= '0;
            lane_idx <= '0;
            mask     <= '0;
        end else if (load) begin
            lanes[lane_idx] <= pix_data;
            lane_idx        <= lane_idx + 1'b1;
            mask            <= lane_mask({1'b0, lane_idx} + 1'b1);
        end
    end

    assign word_data = lanes;
    assign byte_en   = mask;
    assign last_lane = (lane_idx == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/img_write_ctrl.sv
// Packs a pixel stream into 32-bit word writes, one image per start, done pulse at the end.
// One WRITE cycle per word minimum; pixel ready drops while a word is waiting on memory.
module img_write_ctrl
    import img_wr_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_length,
    input  logic              i_pix_valid,
    input  logic [7:0]        i_pix_data,
    output logic              o_pix_ready,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_byte_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_pix_count
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  cnt_inc;
    logic              start_acc;
    logic              pix_fire;
    logic              mem_fire;
    logic              last_lane;
    logic              base_lsb_unused;

    // Base is forced word-aligned, so its low bits are never consumed.
    assign base_lsb_unused = ^i_base_addr[1:0];
    assign cnt_inc         = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        pix_fire  = 1'b0;
        mem_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_nxt = (i_length == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (i_pix_valid) begin
                    pix_fire = 1'b1;
                    if (last_lane || (cnt_inc == len_q)) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                if (i_mem_ready) begin
                    mem_fire  = 1'b1;
                    state_nxt = (cnt_q == len_q) ? DONE : COLLECT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (start_acc) begin
                addr_q <= {i_base_addr[ADDR_W-1:2], 2'b00};
                len_q  <= i_length;
                cnt_q  <= '0;
            end
            if (pix_fire) begin
                cnt_q <= cnt_inc;
            end
            if (mem_fire) begin
                addr_q <= addr_q + ADDR_W'(BYTES_PER_WORD);
            end
        end
    end

    pixel_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pix_fire),
        .clear     (mem_fire),
        .pix_data  (i_pix_data),
        .word_data (o_mem_wdata),
        .byte_en   (o_mem_byte_en),
        .last_lane (last_lane)
    );

    assign o_pix_ready = (state == COLLECT);
    assign o_mem_we    = (state == WRITE);
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign o_mem_addr  = addr_q;
    assign o_pix_count = cnt_q;

endmodule

// File: tb/tb_img_write_ctrl.sv
// Bench for img_write_ctrl: directed table, multi-cycle corner sequences and random images vs. a word model.
`timescale 1ns/1ps
module tb_img_write_ctrl;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [LEN_W-1:0]  i_length = '0;
    logic              i_pix_valid = 1'b0;
    logic [7:0]        i_pix_data = '0;
    logic              o_pix_ready;
    logic              o_mem_we;
    logic [3:0]        o_mem_byte_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_ready = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic [LEN_W-1:0]  o_pix_count;

    always #5 clk = ~clk;

    img_write_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_length      (i_length),
        .i_pix_valid   (i_pix_valid),
        .i_pix_data    (i_pix_data),
        .o_pix_ready   (o_pix_ready),
        .o_mem_we      (o_mem_we),
        .o_mem_byte_en (o_mem_byte_en),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_ready   (i_mem_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_pix_count   (o_pix_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int unsigned valid_pct = 100;
    int unsigned ready_pct = 100;
    bit          hold_ready = 1'b0;
    logic [7:0]  pix_q[$];
    logic [7:0]  img_pix[$];
    logic [15:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  wb[$];
    bit          stall_prev = 1'b0;
    logic [15:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_be;

    typedef struct {
        logic [15:0] base;
        int unsigned len;
        logic [7:0]  p0;
        int unsigned n_wr;
        logic [15:0] first_addr;
        logic [15:0] last_addr;
        logic [31:0] last_data;
        logic [3:0]  last_be;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel source and memory-ready generator, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pix_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            i_pix_valid = 1'b1;
            i_pix_data  = pix_q[0];
        end else begin
            i_pix_valid = 1'b0;
            i_pix_data  = 8'($urandom);
        end
        i_mem_ready = !hold_ready && ($urandom_range(99) < ready_pct);
    end

    // Observes handshakes half a cycle before the edge that completes them.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_we", {63'd0, o_mem_we}, 64'd1);
                chk("stall_addr", {48'd0, o_mem_addr}, {48'd0, s_addr});
                chk("stall_data", {32'd0, o_mem_wdata}, {32'd0, s_data});
                chk("stall_be", {60'd0, o_mem_byte_en}, {60'd0, s_be});
            end
            if (o_pix_ready && o_mem_we) chk("ready_and_we", 64'd1, 64'd0);
            if (o_pix_ready && i_pix_valid && pix_q.size() > 0) void'(pix_q.pop_front());
            if (o_mem_we && i_mem_ready) begin
                wa.push_back(o_mem_addr);
                wd.push_back(o_mem_wdata);
                wb.push_back(o_mem_byte_en);
                last_wr_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = o_mem_we && !i_mem_ready;
            s_addr = o_mem_addr;
            s_data = o_mem_wdata;
            s_be   = o_mem_byte_en;
        end
    end

    task automatic start_image(input logic [15:0] base, input int unsigned len);
        wa.delete(); wd.delete(); wb.delete();
        done_cnt = 0;
        pix_q = img_pix;
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = base; i_length = len;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned len, input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (o_done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " done_seen"}, {63'd0, got}, 64'd1);
        if (got) begin
            chk({tag, " busy_at_done"}, {63'd0, o_busy}, 64'd1);
            chk({tag, " pix_count"}, {32'd0, o_pix_count}, {32'd0, len});
            @(negedge clk);
            chk({tag, " done_width"}, {63'd0, o_done}, 64'd0);
            chk({tag, " busy_after"}, {63'd0, o_busy}, 64'd0);
            chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
            if (len > 0) chk({tag, " done_latency"}, 64'(done_cyc - last_wr_cyc), 64'd1);
        end
    endtask

    // Expected words straight from the pixel list: groups of four, little-endian lanes.
    task automatic check_model(input logic [15:0] base, input int unsigned len, input string tag);
        int unsigned nw, cnt;
        logic [15:0] ea;
        logic [31:0] ed;
        logic [3:0]  eb;
        nw = (len + 3) / 4;
        chk({tag, " n_writes"}, 64'(wa.size()), 64'(nw));
        for (int w = 0; w < int'(nw) && w < wa.size(); w++) begin
            cnt = (len - 4 * w > 4) ? 4 : len - 4 * w;
            ea  = 16'((int'(base) & 'hFFFC) + 4 * w);
            ed  = '0;
            for (int b = 0; b < int'(cnt); b++) ed = ed | (32'(img_pix[4 * w + b]) << (8 * b));
            eb  = 4'((1 << cnt) - 1);
            chk($sformatf("%s w%0d addr", tag, w), {48'd0, wa[w]}, {48'd0, ea});
            chk($sformatf("%s w%0d data", tag, w), {32'd0, wd[w]}, {32'd0, ed});
            chk($sformatf("%s w%0d be", tag, w), {60'd0, wb[w]}, {60'd0, eb});
        end
        chk({tag, " pixels_left"}, 64'(pix_q.size()), 64'd0);
    endtask

    task automatic run_image(input logic [15:0] base, input int unsigned len, input string tag);
        start_image(base, len);
        wait_done(len, tag);
        check_model(base, len, tag);
    endtask

    initial begin
        tbl[0] = '{16'h0100, 8, 8'h01, 2, 16'h0100, 16'h0104, 32'h08070605, 4'b1111};
        tbl[1] = '{16'h0200, 6, 8'hA0, 2, 16'h0200, 16'h0204, 32'h0000A5A4, 4'b0011};
        tbl[2] = '{16'hFFFC, 8, 8'h30, 2, 16'hFFFC, 16'h0000, 32'h37363534, 4'b1111};
        tbl[3] = '{16'h0303, 1, 8'h55, 1, 16'h0300, 16'h0300, 32'h00000055, 4'b0001};
        tbl[4] = '{16'h0010, 3, 8'h10, 1, 16'h0010, 16'h0010, 32'h00121110, 4'b0111};

        repeat (2) @(negedge clk);
        chk("rst pix_ready", {63'd0, o_pix_ready}, 64'd0);
        chk("rst mem_we", {63'd0, o_mem_we}, 64'd0);
        chk("rst addr", {48'd0, o_mem_addr}, 64'd0);
        chk("rst wdata", {32'd0, o_mem_wdata}, 64'd0);
        chk("rst be", {60'd0, o_mem_byte_en}, 64'd0);
        chk("rst busy_done", {62'd0, o_busy, o_done}, 64'd0);
        chk("rst count", {32'd0, o_pix_count}, 64'd0);
        rst_n = 1'b1;

        // Directed table at full rate.
        for (int t = 0; t < 5; t++) begin
            img_pix.delete();
            for (int i = 0; i < int'(tbl[t].len); i++) img_pix.push_back(8'(int'(tbl[t].p0) + i));
            run_image(tbl[t].base, tbl[t].len, $sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d n_wr", t), 64'(wa.size()), 64'(tbl[t].n_wr));
            if (wa.size() == int'(tbl[t].n_wr)) begin
                chk($sformatf("tbl%0d first_addr", t), {48'd0, wa[0]}, {48'd0, tbl[t].first_addr});
                chk($sformatf("tbl%0d last_addr", t), {48'd0, wa[$]}, {48'd0, tbl[t].last_addr});
                chk($sformatf("tbl%0d last_data", t), {32'd0, wd[$]}, {32'd0, tbl[t].last_data});
                chk($sformatf("tbl%0d last_be", t), {60'd0, wb[$]}, {60'd0, tbl[t].last_be});
            end
        end

        // Zero-length image: done the cycle after start, no write.
        wa.delete(); done_cnt = 0;
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = 16'h0700; i_length = 0;
        @(negedge clk);
        chk("len0 pre busy", {63'd0, o_busy}, 64'd0);
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk("len0 done", {63'd0, o_done}, 64'd1);
        chk("len0 busy", {63'd0, o_busy}, 64'd1);
        @(negedge clk);
        chk("len0 done_after", {63'd0, o_done}, 64'd0);
        chk("len0 busy_after", {63'd0, o_busy}, 64'd0);
        chk("len0 writes", 64'(wa.size()), 64'd0);

        // Memory stall for three WRITE cycles, with a stray start that must be ignored.
        img_pix = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        hold_ready = 1'b1;
        start_image(16'h0600, 4);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (o_mem_we) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("stall we_seen", {63'd0, seen}, 64'd1);
            chk("stall first_ready", {63'd0, o_pix_ready}, 64'd0);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                if (k == 0) begin
                    i_start = 1'b1; i_length = 9;
                end else begin
                    i_start = 1'b0;
                end
                @(negedge clk);
                chk($sformatf("stall%0d we", k), {63'd0, o_mem_we}, 64'd1);
                chk($sformatf("stall%0d pix_ready", k), {63'd0, o_pix_ready}, 64'd0);
                chk($sformatf("stall%0d addr", k), {48'd0, o_mem_addr}, 64'h0600);
                chk($sformatf("stall%0d data", k), {32'd0, o_mem_wdata}, 64'hC4C3C2C1);
                chk($sformatf("stall%0d be", k), {60'd0, o_mem_byte_en}, 64'hF);
                if (k == 1) hold_ready = 1'b0;
            end
        end
        wait_done(4, "stall");
        check_model(16'h0600, 4, "stall");

        // Reset in the middle of an image, then a clean image from a new base.
        img_pix.delete();
        for (int i = 0; i < 8; i++) img_pix.push_back(8'(8'h60 + i));
        start_image(16'h0400, 8);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (o_pix_count == 5) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("rstmid count5_seen", {63'd0, seen}, 64'd1);
        end
        rst_n = 1'b0;
        pix_q.delete();
        #1;
        chk("rstmid pix_ready", {63'd0, o_pix_ready}, 64'd0);
        chk("rstmid we", {63'd0, o_mem_we}, 64'd0);
        chk("rstmid addr", {48'd0, o_mem_addr}, 64'd0);
        chk("rstmid wdata", {32'd0, o_mem_wdata}, 64'd0);
        chk("rstmid be", {60'd0, o_mem_byte_en}, 64'd0);
        chk("rstmid busy_done", {62'd0, o_busy, o_done}, 64'd0);
        chk("rstmid count", {32'd0, o_pix_count}, 64'd0);
        done_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid no_done", 64'(done_cnt), 64'd0);
        img_pix = '{8'h91, 8'h92, 8'h93, 8'h94};
        run_image(16'h0500, 4, "post_rst");

        // Random images with random pixel gaps and memory stalls.
        for (int r = 0; r < 25; r++) begin
            int unsigned len;
            logic [15:0] base;
            len  = $urandom_range(0, 14);
            base = 16'($urandom);
            valid_pct = $urandom_range(30, 100);
            ready_pct = $urandom_range(30, 100);
            img_pix.delete();
            for (int i = 0; i < int'(len); i++) img_pix.push_back(8'($urandom));
            run_image(base, len, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
